// File: rtl/fan_health_monitor.sv
// fan_health_monitor: sits behind the fan controller. Smooths both tach
// readbacks with an EMA filter, flags fans running below a tolerance band of
// the commanded RPM, and drives the controller's active-low Alert_Clear with
// a bounded retry policy that latches a hard fault when retries run out.
//
// There is no valid/ready pairing on this block: every input is sampled
// continuously and the only qualifier is the internal sample strobe, which
// fires once every SAMPLE_DIV cycles. fsm_state_dbg exposes the alert FSM
// state (0 IDLE, 1 CLEAR, 2 HOLDOFF, 3 LATCHED).
module fan_health_monitor #(
  parameter int SAMPLE_DIV     = 2000,
  parameter int AVG_SHIFT      = 3,
  parameter int TOL_SHIFT      = 2,
  parameter int SETTLE_SAMPLES = 64,
  parameter int STALL_SAMPLES  = 16,
  parameter int CLEAR_CYCLES   = 50,
  parameter int RECOVER_CYCLES = 33554432,
  parameter int MAX_RETRY      = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] Speed_Set,
  input  logic [13:0] FAN0_Speed,
  input  logic [13:0] FAN1_Speed,
  input  logic [3:0]  Alert_Type,
  output logic        Alert_Clear,
  output logic [13:0] FAN0_Avg,
  output logic [13:0] FAN1_Avg,
  output logic [1:0]  Fan_Fault,
  output logic        Alert_Latched,
  output logic [1:0]  Retry_Count,
  output logic [1:0]  fsm_state_dbg
);

  localparam int CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W   = 14 + AVG_SHIFT;
  localparam int SET_W   = $clog2(SETTLE_SAMPLES + 1);
  localparam int LOW_W   = $clog2(STALL_SAMPLES + 1);
  localparam int TMR_MAX = (RECOVER_CYCLES > CLEAR_CYCLES) ? RECOVER_CYCLES : CLEAR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [SET_W-1:0] SETTLE_INIT  = SET_W'(SETTLE_SAMPLES);
  localparam logic [LOW_W-1:0] LOW_SAT      = LOW_W'(STALL_SAMPLES);
  localparam logic [TMR_W-1:0] CLEAR_LAST   = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] RECOVER_LAST = TMR_W'(RECOVER_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_LATCHED = 2'd3
  } state_t;

  // Registered copies of the inputs; everything downstream uses these.
  logic [12:0]           set_q, set_d;
  logic [12:0]           set_prev_q, set_prev_d;
  logic [1:0][13:0]      fan_q, fan_d;
  logic [3:0]            alert_q, alert_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  strobe;

  logic                  primed_q, primed_d;
  logic [1:0][ACC_W-1:0] acc_q, acc_d;
  logic [1:0][13:0]      avg;

  logic [SET_W-1:0]      settle_q, settle_d;
  logic [1:0][LOW_W-1:0] low_q, low_d;
  logic [12:0]           thr;
  logic                  set_changed;
  logic                  eval_en;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [1:0]            retry_q, retry_d;
  logic                  clr_n_q, clr_n_d;

  assign avg[0]      = acc_q[0][ACC_W-1:AVG_SHIFT];
  assign avg[1]      = acc_q[1][ACC_W-1:AVG_SHIFT];
  assign strobe      = (cnt_q == CNT_LAST);
  assign set_changed = (set_q != set_prev_q);
  // Threshold stays 13 bits; it is zero-extended at the compare.
  assign thr         = set_q - (set_q >> TOL_SHIFT);
  assign eval_en     = strobe && (settle_q == '0) && (set_q != '0);

  // Input capture stage plus the one-deep history used to spot setpoint changes.
  always_comb begin
    set_d      = Speed_Set;
    set_prev_d = set_q;
    fan_d[0]   = FAN0_Speed;
    fan_d[1]   = FAN1_Speed;
    alert_d    = Alert_Type;
  end

  // Sample divider: wraps at SAMPLE_DIV-1, strobe marks the wrap cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (strobe) begin
      cnt_d = '0;
    end
  end

  // EMA filter; the very first strobe preloads so the average never ramps from 0.
  // The update cannot overflow: its true value never exceeds max_input << AVG_SHIFT.
  always_comb begin
    primed_d = primed_q;
    acc_d    = acc_q;
    if (strobe) begin
      primed_d = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!primed_q) begin
          acc_d[i] = ACC_W'(fan_q[i]) << AVG_SHIFT;
        end else begin
          acc_d[i] = acc_q[i] + ACC_W'(fan_q[i]) - (acc_q[i] >> AVG_SHIFT);
        end
      end
    end
  end

  // Settle window and per-fan consecutive-low counters (saturating).
  always_comb begin
    settle_d = settle_q;
    low_d    = low_q;
    if (set_changed) begin
      settle_d = SETTLE_INIT;
      low_d    = '0;
    end else begin
      if (strobe && (settle_q != '0)) begin
        settle_d = settle_q - SET_W'(1);
      end
      if (set_q == '0) begin
        low_d = '0;
      end else if (eval_en) begin
        for (int i = 0; i < 2; i++) begin
          if (avg[i] < {1'b0, thr}) begin
            low_d[i] = (low_q[i] == LOW_SAT) ? low_q[i] : (low_q[i] + LOW_W'(1));
          end else begin
            low_d[i] = '0;
          end
        end
      end
    end
  end

  // Alert clear FSM: next state, timer, retry count and registered clear level.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    clr_n_d = clr_n_q;
    case (state_q)
      ST_IDLE: begin
        if (alert_q != '0) begin
          state_d = ST_CLEAR;
          retry_d = retry_q + 2'd1;
          tmr_d   = '0;
          clr_n_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (tmr_q == CLEAR_LAST) begin
          state_d = ST_HOLDOFF;
          tmr_d   = '0;
          clr_n_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_HOLDOFF: begin
        // Alert_Type is only looked at once the recovery window expires.
        if (tmr_q == RECOVER_LAST) begin
          tmr_d = '0;
          if (alert_q == '0) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end else if (retry_q < RETRY_MAX) begin
            state_d = ST_CLEAR;
            retry_d = retry_q + 2'd1;
            clr_n_d = 1'b0;
          end else begin
            state_d = ST_LATCHED;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_LATCHED: begin
        clr_n_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
        retry_d = '0;
        clr_n_d = 1'b1;
      end
    endcase
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      set_q      <= '0;
      set_prev_q <= '0;
      fan_q      <= '0;
      alert_q    <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      acc_q      <= '0;
      settle_q   <= SETTLE_INIT;
      low_q      <= '0;
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      retry_q    <= '0;
      clr_n_q    <= 1'b1;
    end else begin
      set_q      <= set_d;
      set_prev_q <= set_prev_d;
      fan_q      <= fan_d;
      alert_q    <= alert_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      acc_q      <= acc_d;
      settle_q   <= settle_d;
      low_q      <= low_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      retry_q    <= retry_d;
      clr_n_q    <= clr_n_d;
    end
  end

  assign FAN0_Avg      = avg[0];
  assign FAN1_Avg      = avg[1];
  assign Fan_Fault[0]  = (low_q[0] == LOW_SAT) && (set_q != '0);
  assign Fan_Fault[1]  = (low_q[1] == LOW_SAT) && (set_q != '0);
  assign Alert_Clear   = clr_n_q;
  assign Alert_Latched = (state_q == ST_LATCHED);
  assign Retry_Count   = retry_q;
  assign fsm_state_dbg = state_q;

endmodule
